line_buf_ctrl: RTL and testbench

//  Sequencer for the delay_mem line-buffer chain ahead of the stream filter.
//  Per frame: loads the row length into every delay_mem (cfg_delay/cfg_set),

---
 rtl/line_buf_ctrl_if.sv | 72 +++++++
 rtl/line_buf_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_ctrl_if.sv
// ----------------------------------------------------------------------------
// line_buf_ctrl_if
//
// Purpose:
//   Bundles the configuration, delay_mem control, upstream handshake and
//   window-status signals of line_buf_ctrl into a single interface.
//
// Modports:
//   master : frame source / test driver side. It drives the cfg_* requests and
//            up_val, and observes everything else.
//   slave  : the line_buf_ctrl sequencer.
//
// Signals (direction as seen by the slave):
//   cfg_width     in   MEM_AWIDTH  pixels per row
//   cfg_height    in   ROW_AWIDTH  rows per frame
//   cfg_start     in   1           start-frame request
//   up_val        in   1           upstream pixel valid
//   cfg_busy      out  1           sequencer not idle
//   cfg_err       out  1           start rejected (bad geometry), 1-cycle pulse
//   mem_cfg_delay out  MEM_AWIDTH  row length to every delay_mem
//   mem_cfg_set   out  1           delay_mem config strobe
//   up_rdy        out  1           upstream ready
//   mem_up_val    out  1           pixel accepted into the delay_mem chain
//   win_val       out  1           full KERNEL x KERNEL window valid
//   win_last_col  out  1           window is in the last column of its row
//   win_last_row  out  1           window is in the last row of the frame
//   frame_done    out  1           frame complete, 1-cycle pulse
//   frame_cnt     out  16          completed frames (LINE_BUF_CTRL_FRAME_CNT_EN)
//
// Build option:
//   LINE_BUF_CTRL_FRAME_CNT_EN adds the frame_cnt signal.
// ----------------------------------------------------------------------------
interface line_buf_ctrl_if #(
  parameter int MEM_AWIDTH = 12,
  parameter int ROW_AWIDTH = 12
);
  logic [MEM_AWIDTH-1:0] cfg_width;
  logic [ROW_AWIDTH-1:0] cfg_height;
  logic                  cfg_start;
  logic                  up_val;
  logic                  cfg_busy;
  logic                  cfg_err;
  logic [MEM_AWIDTH-1:0] mem_cfg_delay;
  logic                  mem_cfg_set;
  logic                  up_rdy;
  logic                  mem_up_val;
  logic                  win_val;
  logic                  win_last_col;
  logic                  win_last_row;
  logic                  frame_done;
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
  logic [15:0]           frame_cnt;
`endif

  modport master (
    output cfg_width, cfg_height, cfg_start, up_val,
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  cfg_busy, cfg_err, mem_cfg_delay, mem_cfg_set, up_rdy, mem_up_val,
           win_val, win_last_col, win_last_row, frame_done
  );

  modport slave (
    input  cfg_width, cfg_height, cfg_start, up_val,
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
    output frame_cnt,
`endif
    output cfg_busy, cfg_err, mem_cfg_delay, mem_cfg_set, up_rdy, mem_up_val,
           win_val, win_last_col, win_last_row, frame_done
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// ----------------------------------------------------------------------------
// line_buf_ctrl
//
// Purpose:
//   Sequencer for the delay_mem line-buffer chain ahead of the stream filter.
//   For each frame it loads the row length into every delay_mem, waits out the
//   delay_mem configuration latency, then gates pixels into the chain while
//   tracking column/row and flagging when a full KERNEL x KERNEL window is
//   available at the delay_mem outputs.
//
// Ports:
//   clk  in  1   clock
//   rst  in  1   synchronous active-high reset
//   bus  line_buf_ctrl_if.slave  (config, delay_mem control, upstream
//        handshake, window status; see line_buf_ctrl_if.sv)
//
// Parameters:
//   MEM_AWIDTH  row-length width, must match delay_mem MEM_AWIDTH
//   ROW_AWIDTH  row counter / frame height width
//   KERNEL      filter window size
//
// Build option:
//   LINE_BUF_CTRL_FRAME_CNT_EN adds a 16-bit wrapping count of completed
//   frames on bus.frame_cnt. Without it the counter does not exist.
// ----------------------------------------------------------------------------
module line_buf_ctrl #(
  parameter int MEM_AWIDTH = 12,
  parameter int ROW_AWIDTH = 12,
  parameter int KERNEL     = 3
) (
  input  logic           clk,
  input  logic           rst,
  line_buf_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_FLUSH,
    S_STREAM,
    S_DONE
  } state_e;

  // Geometry limits at full counter width.
  localparam logic [MEM_AWIDTH-1:0] COL_MIN  = MEM_AWIDTH'(KERNEL);
  localparam logic [ROW_AWIDTH-1:0] ROW_MIN  = ROW_AWIDTH'(KERNEL);
  localparam logic [MEM_AWIDTH-1:0] COL_EDGE = MEM_AWIDTH'(KERNEL - 1);
  localparam logic [ROW_AWIDTH-1:0] ROW_EDGE = ROW_AWIDTH'(KERNEL - 1);
  localparam logic [MEM_AWIDTH-1:0] COL_ONE  = MEM_AWIDTH'(1);
  localparam logic [ROW_AWIDTH-1:0] ROW_ONE  = ROW_AWIDTH'(1);

  state_e                state_q, state_d;
  logic                  flush_q, flush_d;     // second FLUSH cycle marker
  logic [MEM_AWIDTH-1:0] width_q, width_d;
  logic [ROW_AWIDTH-1:0] height_q, height_d;
  logic [MEM_AWIDTH-1:0] col_q, col_d;
  logic [ROW_AWIDTH-1:0] row_q, row_d;
  logic                  err_q, err_d;
  logic                  win_val_q, win_val_d;
  logic                  win_last_col_q, win_last_col_d;
  logic                  win_last_row_q, win_last_row_d;
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
  logic [15:0]           frame_cnt_q, frame_cnt_d;
`endif

  logic geom_ok;
  logic start_req;
  logic accept;
  logic last_col;
  logic last_row;

  assign geom_ok   = (bus.cfg_width >= COL_MIN) && (bus.cfg_height >= ROW_MIN);
  assign start_req = (state_q == S_IDLE) && bus.cfg_start;
  assign accept    = bus.up_val && (state_q == S_STREAM);
  assign last_col  = (col_q == width_q - COL_ONE);
  assign last_row  = (row_q == height_q - ROW_ONE);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order across always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start_req && geom_ok) state_d = S_CONFIG;
      S_CONFIG: state_d = S_FLUSH;
      S_FLUSH: begin
        // Two cycles: delay_mem cfg register, then its pointer reset.
        flush_d = 1'b1;
        if (flush_q) state_d = S_STREAM;
      end
      S_STREAM: if (accept && last_col && last_row) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.cfg_busy      = (state_q != S_IDLE);
    bus.mem_cfg_set   = (state_q == S_CONFIG);
    bus.up_rdy        = (state_q == S_STREAM);
    bus.frame_done    = (state_q == S_DONE);
    bus.mem_up_val    = accept;
    bus.mem_cfg_delay = width_q;
    bus.cfg_err       = err_q;
    bus.win_val       = win_val_q;
    bus.win_last_col  = win_last_col_q;
    bus.win_last_row  = win_last_row_q;
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
    bus.frame_cnt     = frame_cnt_q;
`endif
  end

  // --------------------------------------------------------------------------
  // Datapath: geometry latch, pixel position, window flags
  // --------------------------------------------------------------------------
  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    err_d    = 1'b0;

    // Rejected starts leave the latched geometry (and mem_cfg_delay) alone.
    if (start_req) begin
      if (geom_ok) begin
        width_d  = bus.cfg_width;
        height_d = bus.cfg_height;
      end else begin
        err_d = 1'b1;
      end
    end

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end

    if (state_q == S_DONE) begin
      col_d = '0;
      row_d = '0;
    end

    // Window flags use the pre-increment position of the accepted pixel and
    // appear one cycle later, in step with delay_mem dn_data.
    win_val_d      = accept && (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);
    win_last_col_d = accept && last_col;
    win_last_row_d = accept && last_row;
  end

`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == S_DONE) frame_cnt_d = frame_cnt_q + 16'd1;  // wraps at 0xFFFF
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q        <= '0;
      height_q       <= '0;
      col_q          <= '0;
      row_q          <= '0;
      err_q          <= 1'b0;
      win_val_q      <= 1'b0;
      win_last_col_q <= 1'b0;
      win_last_row_q <= 1'b0;
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
      frame_cnt_q    <= '0;
`endif
    end else begin
      width_q        <= width_d;
      height_q       <= height_d;
      col_q          <= col_d;
      row_q          <= row_d;
      err_q          <= err_d;
      win_val_q      <= win_val_d;
      win_last_col_q <= win_last_col_d;
      win_last_row_q <= win_last_row_d;
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
      frame_cnt_q    <= frame_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// ----------------------------------------------------------------------------
// tb_line_buf_ctrl
//
// Scoreboard bench for line_buf_ctrl (KERNEL=3). Stimulus pushes the expected
// output events (mem_cfg_set, win_val, frame_done, cfg_err, each with the
// cycle it must appear in) into queues; a monitor on the falling edge pops
// and compares whenever the DUT raises one of those outputs. Any output raised
// with an empty queue is reported as spurious.
// ----------------------------------------------------------------------------
module tb_line_buf_ctrl;

  localparam int MAW = 12;
  localparam int RAW = 12;

  typedef struct {
    int           cyc;
    logic [11:0]  delay;
    logic         lc;
    logic         lr;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   up_mode = 0;     // 0: up_val held high, 1: up_val toggles 1010...
  int   up_base = 0;     // cycle where the toggle pattern starts with a 1
  int   frames_exp = 0;

  ev_t win_q[$];
  ev_t set_q[$];
  ev_t done_q[$];
  ev_t err_q[$];

  line_buf_ctrl_if #(.MEM_AWIDTH(MAW), .ROW_AWIDTH(RAW)) lb ();

  line_buf_ctrl #(.MEM_AWIDTH(MAW), .ROW_AWIDTH(RAW), .KERNEL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    ev_t e;
    if (lb.win_val) begin
      if (win_q.size() == 0) check("win_spurious", lb.win_val, 1'b0);
      else begin
        e = win_q.pop_front();
        check("win", {cyc, lb.win_last_col, lb.win_last_row}, {e.cyc, e.lc, e.lr});
      end
    end
    if (lb.mem_cfg_set) begin
      if (set_q.size() == 0) check("cfg_set_spurious", lb.mem_cfg_set, 1'b0);
      else begin
        e = set_q.pop_front();
        check("cfg_set", {cyc, lb.mem_cfg_delay}, {e.cyc, e.delay});
      end
    end
    if (lb.frame_done) begin
      if (done_q.size() == 0) check("done_spurious", lb.frame_done, 1'b0);
      else begin
        e = done_q.pop_front();
        check("frame_done", cyc, e.cyc);
      end
    end
    if (lb.cfg_err) begin
      if (err_q.size() == 0) check("err_spurious", lb.cfg_err, 1'b0);
      else begin
        e = err_q.pop_front();
        check("cfg_err", cyc, e.cyc);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Advance one cycle; inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    lb.up_val = (up_mode == 0) ? 1'b1 : (((cyc - up_base) % 2) == 0);
  endtask

  // Reference model of one frame started by a cfg_start sampled at edge e:
  // CONFIG during cycle e, FLUSH e+1..e+2, STREAM from e+3.
  task automatic expect_frame(input int e, input int w, input int h, input int mode);
    ev_t ev;
    int  t;
    ev.cyc = e; ev.delay = 12'(w); ev.lc = 1'b0; ev.lr = 1'b0;
    set_q.push_back(ev);
    t = e + 3;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (mode == 1) while (((t - (e + 3)) % 2) != 0) t++;
        if (r >= 2 && c >= 2) begin
          ev.cyc = t + 1; ev.delay = '0; ev.lc = (c == w - 1); ev.lr = (r == h - 1);
          win_q.push_back(ev);
        end
        t++;
      end
    end
    ev.cyc = t; ev.delay = '0; ev.lc = 1'b0; ev.lr = 1'b0;
    done_q.push_back(ev);
    frames_exp++;
  endtask

  // kind 0: full frame expected, 1: rejected start, 2: config only (aborted).
  // Returns the edge index e at which cfg_start is sampled; on return the
  // bench is in cycle e.
  task automatic start_frame(input int w, input int h, input int mode, input int kind,
                             output int e);
    ev_t ev;
    tick();
    lb.cfg_width  = 12'(w);
    lb.cfg_height = 12'(h);
    lb.cfg_start  = 1'b1;
    e = cyc + 1;
    up_mode = mode;
    up_base = e + 3;
    ev.cyc = e; ev.delay = 12'(w); ev.lc = 1'b0; ev.lr = 1'b0;
    if (kind == 0) expect_frame(e, w, h, mode);
    else if (kind == 1) err_q.push_back(ev);
    else set_q.push_back(ev);
    tick();
    lb.cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((win_q.size() + set_q.size() + done_q.size() + err_q.size() != 0 || lb.cfg_busy)
           && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (n < budget), 1'b1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    frames_exp = 0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {lb.cfg_busy, lb.cfg_err, lb.mem_cfg_delay, lb.mem_cfg_set, lb.up_rdy,
                 lb.mem_up_val, lb.win_val, lb.win_last_col, lb.win_last_row, lb.frame_done},
          '0);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int e;
    rst           = 1'b1;
    lb.cfg_width  = '0;
    lb.cfg_height = '0;
    lb.cfg_start  = 1'b0;
    lb.up_val     = 1'b0;
    repeat (3) tick();
    // up_val is already high here: up_rdy must still gate mem_up_val.
    check_all_zero("reset_outputs");
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
    check("reset_frame_cnt", lb.frame_cnt, 16'd0);
`endif
    rst = 1'b0;
    tick();
    check_all_zero("idle_outputs");

    // 1: 4x4, up_val held high; up_rdy rises 3 cycles after mem_cfg_set.
    start_frame(4, 4, 0, 0, e);
    check("busy_in_config", lb.cfg_busy, 1'b1);
    tick(); tick();
    check("up_rdy_flush", lb.up_rdy, 1'b0);
    tick();
    check("up_rdy_stream", lb.up_rdy, 1'b1);
    check("mem_up_val_stream", lb.mem_up_val, 1'b1);
    wait_idle("t1", 60);

    // 2: same frame with up_val toggling.
    start_frame(4, 4, 1, 0, e);
    wait_idle("t2", 80);

    // 3: bad geometry (width and height below KERNEL) is rejected.
    start_frame(2, 4, 0, 1, e);
    check("busy_after_bad_width", lb.cfg_busy, 1'b0);
    wait_idle("t3a", 10);
    start_frame(4, 2, 0, 1, e);
    check("busy_after_bad_height", lb.cfg_busy, 1'b0);
    wait_idle("t3b", 10);
    check("cfg_delay_after_reject", lb.mem_cfg_delay, 12'd4);

    // 4: cfg_start during STREAM is ignored.
    start_frame(4, 4, 0, 0, e);
    repeat (6) tick();
    lb.cfg_width  = 12'd8;
    lb.cfg_height = 12'd8;
    lb.cfg_start  = 1'b1;
    tick();
    lb.cfg_start  = 1'b0;
    wait_idle("t4", 60);
    check("cfg_delay_held", lb.mem_cfg_delay, 12'd4);

    // 5: reset while the 7th pixel is accepted abandons the frame.
    start_frame(4, 4, 0, 2, e);
    repeat (9) tick();
    check("accept_before_reset", lb.mem_up_val, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frames_exp = 0;
    check_all_zero("mid_frame_reset");
    repeat (4) tick();
    check_all_zero("after_reset_quiet");
    // Minimal legal geometry, toggling up_val.
    start_frame(3, 3, 1, 0, e);
    wait_idle("t5", 60);

    // 6: three back-to-back frames after a fresh reset.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      start_frame(4, 4, 0, 0, e);
      wait_idle("t6", 60);
    end
`ifdef LINE_BUF_CTRL_FRAME_CNT_EN
    check("frame_cnt", lb.frame_cnt, 16'd3);
`endif
    check("frames_modelled", frames_exp, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
